// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker: finds the decoder latency against a tx history,
// locks onto it, then counts decoded bits/errors and flags loss of lock.
module viterbi_ber_checker #(
  parameter int HIST_DEPTH  = 64,
  parameter int LOCK_LEN    = 32,
  parameter int WIN         = 32,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid_i,
  input  logic                          tx_bit_i,
  input  logic                          rx_valid_i,
  input  logic                          rx_bit_i,
  input  logic                          clear_i,
  output logic [1:0]                    state_o,
  output logic                          locked_o,
  output logic [$clog2(HIST_DEPTH)-1:0] lat_o,
  output logic [CNT_W-1:0]              bit_ct_o,
  output logic [CNT_W-1:0]              err_ct_o,
  output logic                          lost_o
);

  localparam int LAT_W  = $clog2(HIST_DEPTH);
  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int WIN_W  = $clog2(WIN);
  localparam int WE_W   = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1
  } state_t;

  state_t                r_state;
  logic                  r_locked;
  logic                  r_lost;
  logic [HIST_DEPTH-1:0] r_hist;
  logic [FILL_W-1:0]     r_fill_ct;
  logic [LAT_W-1:0]      r_lat;
  logic [RUN_W-1:0]      r_run_ct;
  logic [WIN_W-1:0]      r_win_ct;
  logic [WE_W-1:0]       r_win_err;
  logic [CNT_W-1:0]      r_bit_ct;
  logic [CNT_W-1:0]      r_err_ct;

  logic                  w_mismatch;
  logic [LAT_W-1:0]      w_lat_next;
  logic [RUN_W-1:0]      w_run_next;
  logic [WE_W-1:0]       w_win_err_next;

  // Compare against the pre-shift history, even when a tx strobe lands this cycle.
  always_comb begin
    w_mismatch     = rx_bit_i ^ r_hist[r_lat];
    w_lat_next     = (r_lat == LAT_W'(HIST_DEPTH - 1)) ? '0 : r_lat + LAT_W'(1);
    w_run_next     = r_run_ct + RUN_W'(1);
    w_win_err_next = r_win_err + WE_W'(w_mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SEARCH;
      r_locked  <= 1'b0;
      r_lost    <= 1'b0;
      r_hist    <= '0;
      r_fill_ct <= '0;
      r_lat     <= '0;
      r_run_ct  <= '0;
      r_win_ct  <= '0;
      r_win_err <= '0;
      r_bit_ct  <= '0;
      r_err_ct  <= '0;
    end else begin
      if (tx_valid_i) begin
        r_hist <= {r_hist[HIST_DEPTH-2:0], tx_bit_i};
        if (r_fill_ct != FILL_W'(HIST_DEPTH))
          r_fill_ct <= r_fill_ct + FILL_W'(1);
      end

      if (clear_i) begin
        r_state   <= SEARCH;
        r_locked  <= 1'b0;
        r_lost    <= 1'b0;
        r_lat     <= '0;
        r_run_ct  <= '0;
        r_win_ct  <= '0;
        r_win_err <= '0;
        r_bit_ct  <= '0;
        r_err_ct  <= '0;
      end else if (rx_valid_i) begin
        case (r_state)
          SEARCH: begin
            if (r_fill_ct > FILL_W'(r_lat)) begin
              if (w_mismatch) begin
                r_run_ct <= '0;
                r_lat    <= w_lat_next;
              end else if (w_run_next == RUN_W'(LOCK_LEN)) begin
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
                r_run_ct  <= '0;
                r_win_ct  <= '0;
                r_win_err <= '0;
                r_bit_ct  <= '0;
                r_err_ct  <= '0;
              end else begin
                r_run_ct <= w_run_next;
              end
            end
          end
          LOCKED: begin
            if (r_bit_ct != '1)
              r_bit_ct <= r_bit_ct + CNT_W'(1);
            if (w_mismatch && (r_err_ct != '1))
              r_err_ct <= r_err_ct + CNT_W'(1);
            if (w_win_err_next >= WE_W'(LOSS_THRESH)) begin
              r_state   <= SEARCH;
              r_locked  <= 1'b0;
              r_lost    <= 1'b1;
              r_lat     <= '0;
              r_run_ct  <= '0;
              r_win_ct  <= '0;
              r_win_err <= '0;
            end else if (r_win_ct == WIN_W'(WIN - 1)) begin
              r_win_ct  <= '0;
              r_win_err <= '0;
            end else begin
              r_win_ct  <= r_win_ct + WIN_W'(1);
              r_win_err <= w_win_err_next;
            end
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o  = r_state;
  assign locked_o = r_locked;
  assign lat_o    = r_lat;
  assign bit_ct_o = r_bit_ct;
  assign err_ct_o = r_err_ct;
  assign lost_o   = r_lost;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: table-driven locked-traffic phases checked
// through an expectation queue, plus hand sequences for lock/clear/reset/wrap.
module tb_viterbi_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_valid_i = 1'b0;
  logic        tx_bit_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic        rx_bit_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [1:0]  state_o;
  logic        locked_o;
  logic [5:0]  lat_o;
  logic [31:0] bit_ct_o;
  logic [31:0] err_ct_o;
  logic        lost_o;

  viterbi_ber_checker #(
    .HIST_DEPTH(64), .LOCK_LEN(32), .WIN(32), .LOSS_THRESH(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
    .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i),
    .clear_i(clear_i),
    .state_o(state_o), .locked_o(locked_o), .lat_o(lat_o),
    .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o), .lost_o(lost_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    bit     relock_before;
    int     nbits;
    int     inv_every;
    longint exp_locked;
    longint exp_lost;
    longint exp_lat;
    longint exp_bit;
    longint exp_err;
  } vec_t;

  vec_t tbl[4];
  vec_t scb[$];
  logic txq[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   delay = 5;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Delay is the history index the rx bit should match (txq tail is hist[0]).
  task automatic step(input bit rxv, input bit inv, input bit clr);
    logic [31:0] r;
    logic        ref_b;
    r = $urandom;
    ref_b = (txq.size() > delay) ? txq[txq.size() - 1 - delay] : r[1];
    tx_valid_i = 1'b1;
    tx_bit_i   = r[0];
    rx_valid_i = rxv;
    rx_bit_i   = ref_b ^ inv;
    clear_i    = clr;
    @(posedge clk);
    txq.push_back(r[0]);
    if (txq.size() > 256) void'(txq.pop_front());
    #1;
    tx_valid_i = 1'b0;
    rx_valid_i = 1'b0;
    clear_i    = 1'b0;
  endtask

  task automatic wait_lock(input string name, input int bound);
    int k = 0;
    while (!locked_o && k < bound) begin
      step(1'b1, 1'b0, 1'b0);
      k++;
    end
    check({name, "_locked"}, longint'(locked_o), 1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_state"},  longint'(state_o),  0);
    check({name, "_locked"}, longint'(locked_o), 0);
    check({name, "_lat"},    longint'(lat_o),    0);
    check({name, "_bit"},    longint'(bit_ct_o), 0);
    check({name, "_err"},    longint'(err_ct_o), 0);
    check({name, "_lost"},   longint'(lost_o),   0);
  endtask

  // Relock after a loss, then the clear-vs-mismatch collision, then relock again.
  task automatic mid_seq();
    wait_lock("relock", 2000);
    check("relock_lat",  longint'(lat_o),    5);
    check("relock_bit",  longint'(bit_ct_o), 0);
    check("relock_err",  longint'(err_ct_o), 0);
    check("relock_lost", longint'(lost_o),   1);
    step(1'b1, 1'b1, 1'b1);
    check_zero("clear_collision");
    wait_lock("relock2", 2000);
    check("relock2_lat", longint'(lat_o), 5);
  endtask

  initial begin
    vec_t e;
    bit   inv;
    bit   ever_locked, seen63, wrapped;
    int   bad_step;
    logic [5:0] prev_lat;

    tbl[0] = '{"clean",  1'b0, 1000, 0,  1, 0, 5, 1000, 0};
    tbl[1] = '{"burst",  1'b0, 8,    1,  0, 1, 0, 1008, 8};
    tbl[2] = '{"sparse", 1'b1, 1024, 16, 1, 0, 5, 1024, 64};
    tbl[3] = '{"burst2", 1'b0, 8,    1,  0, 1, 0, 1032, 72};

    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(negedge clk) rst = 1'b0;

    delay = 5;
    wait_lock("lock5", 2000);
    check("lock5_lat", longint'(lat_o),    5);
    check("lock5_bit", longint'(bit_ct_o), 0);
    check("lock5_err", longint'(err_ct_o), 0);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].relock_before) mid_seq();
      for (int n = 1; n <= tbl[i].nbits; n++) begin
        inv = (tbl[i].inv_every != 0) && (n % tbl[i].inv_every == 0);
        if (n == tbl[i].nbits) scb.push_back(tbl[i]);
        step(1'b1, inv, 1'b0);
      end
      while (scb.size() > 0) begin
        e = scb.pop_front();
        check({e.name, "_locked"}, longint'(locked_o), e.exp_locked);
        check({e.name, "_lost"},   longint'(lost_o),   e.exp_lost);
        check({e.name, "_lat"},    longint'(lat_o),    e.exp_lat);
        check({e.name, "_bit"},    longint'(bit_ct_o), e.exp_bit);
        check({e.name, "_err"},    longint'(err_ct_o), e.exp_err);
        check({e.name, "_state"},  longint'(state_o),  e.exp_locked);
      end
    end

    // Zero latency: lock must come on exactly the 32nd consecutive match.
    step(1'b0, 1'b0, 1'b1);
    delay = 0;
    for (int n = 0; n < 31; n++) step(1'b1, 1'b0, 1'b0);
    check("lat0_31_locked", longint'(locked_o), 0);
    check("lat0_31_state",  longint'(state_o),  0);
    step(1'b1, 1'b0, 1'b0);
    check("lat0_32_locked", longint'(locked_o), 1);
    check("lat0_32_state",  longint'(state_o),  1);
    check("lat0_32_lat",    longint'(lat_o),    0);
    check("lat0_32_bit",    longint'(bit_ct_o), 0);

    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b0);
    check("pre_rst_bit", longint'(bit_ct_o), 5);
    rst = 1'b1;
    txq.delete();
    #2 check_zero("mid_rst");
    @(posedge clk); #1;
    check("mid_rst_held_locked", longint'(locked_o), 0);
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_locked", longint'(locked_o), 0);
    check("post_rst_lat",    longint'(lat_o),    0);

    // Latency beyond the history depth: never locks, lat walks and wraps.
    delay = 70;
    ever_locked = 1'b0;
    seen63 = 1'b0;
    wrapped = 1'b0;
    bad_step = 0;
    prev_lat = lat_o;
    for (int n = 0; n < 1500; n++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked_o) ever_locked = 1'b1;
      if (lat_o == 6'd63) seen63 = 1'b1;
      if (seen63 && prev_lat == 6'd63 && lat_o == 6'd0) wrapped = 1'b1;
      if (lat_o != prev_lat && lat_o != prev_lat + 6'd1) bad_step++;
      prev_lat = lat_o;
    end
    check("wrap_never_locked", longint'(ever_locked), 0);
    check("wrap_saw_63",       longint'(seen63),      1);
    check("wrap_to_0",         longint'(wrapped),     1);
    check("wrap_bad_steps",    longint'(bad_step),    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
